// File: rtl/anf_aufbereitung.sv
// ==== anf_aufbereitung : pedestrian request conditioning (sync, debounce, hold, lockout, stuck detect)
// ==== Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module anf_aufbereitung #(
  parameter int DEB_CYC   = 4,
  parameter int SPERR_CYC = 8,
  parameter int STUCK_CYC = 64
) (
  input  logic CLK,
  input  logic RES,
  input  logic TASTER,
  input  logic QUIT,
  output logic ANF,
  output logic WARTE,
  output logic STOER
);

  localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYC - 1);
  localparam logic [7:0]  LOCK_INIT  = 8'(SPERR_CYC);
  localparam logic [11:0] STUCK_MAX  = 12'(STUCK_CYC);
  localparam logic [11:0] STUCK_LAST = 12'(STUCK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ANGEFORDERT = 2'd1,
    SPERRE      = 2'd2
  } state_t;

  logic        s1_q;
  logic        s2_q;
  logic        deb_q;
  logic        deb_prev_q;
  logic [7:0]  deb_cnt_q;
  logic [11:0] stuck_cnt_q;
  logic        stoer_q;
  state_t      state_q;
  state_t      state_d;
  logic [7:0]  lock_q;
  logic [7:0]  lock_d;
  logic        press;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= TASTER;
      s2_q <= s1_q;
    end
  end

  // deb follows s2 only after DEB_CYC consecutive disagreeing edges
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= 8'd0;
    end else begin
      deb_prev_q <= deb_q;
      if (s2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_q     <= ~deb_q;
          deb_cnt_q <= 8'd0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 8'd1;
        end
      end else begin
        deb_cnt_q <= 8'd0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      stuck_cnt_q <= 12'd0;
      stoer_q     <= 1'b0;
    end else if (!deb_q) begin
      stuck_cnt_q <= 12'd0;
      stoer_q     <= 1'b0;
    end else if (stuck_cnt_q != STUCK_MAX) begin
      stuck_cnt_q <= stuck_cnt_q + 12'd1;
      if (stuck_cnt_q == STUCK_LAST) begin
        stoer_q <= 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q & ~stoer_q;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= IDLE;
      lock_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // lock_q holds the remaining lockout cycles including the current one
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = ANGEFORDERT;
        end
      end
      ANGEFORDERT: begin
        if (QUIT) begin
          state_d = SPERRE;
          lock_d  = LOCK_INIT;
        end
      end
      SPERRE: begin
        if (lock_q <= 8'd1) begin
          state_d = IDLE;
          lock_d  = 8'd0;
        end else begin
          lock_d = lock_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        lock_d  = 8'd0;
      end
    endcase
  end

  assign ANF   = (state_q == ANGEFORDERT);
  assign WARTE = ANF;
  assign STOER = stoer_q;

endmodule

`default_nettype wire
